// File: rtl/wisc_pkg.sv
// Shared WISC definitions: ALU opcodes, flag bit positions, branch condition
// codes and the flag/branch unit state encoding.
package wisc_pkg;

   localparam logic [2:0] ALU_ADD    = 3'd0;
   localparam logic [2:0] ALU_SUB    = 3'd1;
   localparam logic [2:0] ALU_XOR    = 3'd2;
   localparam logic [2:0] ALU_RED    = 3'd3;
   localparam logic [2:0] ALU_PADDSB = 3'd4;
   localparam logic [2:0] ALU_SRA    = 3'd5;
   localparam logic [2:0] ALU_ROR    = 3'd6;
   localparam logic [2:0] ALU_SLL    = 3'd7;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [2:0] {
      BR_NEQ    = 3'b000,
      BR_EQ     = 3'b001,
      BR_GT     = 3'b010,
      BR_LT     = 3'b011,
      BR_GTE    = 3'b100,
      BR_LTE    = 3'b101,
      BR_OVFL   = 3'b110,
      BR_UNCOND = 3'b111
   } br_cond_t;

   typedef enum logic [1:0] {
      FBU_IDLE       = 2'd0,
      FBU_WAIT_FLAGS = 2'd1,
      FBU_RESOLVE    = 2'd2
   } fbu_state_t;

   // Shifts (5-7) never touch the flags; everything below them does.
   function automatic logic is_flag_op(input logic [2:0] op);
      return op <= ALU_PADDSB;
   endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Bundle between ALU writeback / decode (master side) and the flag branch unit
// (slave side), plus the unit's debug view of its FSM and outstanding counter.
interface flag_branch_unit_if #(
   parameter int PC_W = 16
);
   import wisc_pkg::*;

   logic            alu_issue;
   logic            alu_done;
   logic [2:0]      alu_op;
   logic [2:0]      alu_flags;
   logic            issue_stall;

   // br_valid/br_ready: a request transfers at a rising edge where both are high;
   // res_valid is a one-cycle strobe with no back-pressure.
   logic            br_valid;
   logic            br_ready;
   logic [2:0]      br_cond;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] pc_plus1;
   logic            flush;
   logic            res_valid;
   logic            res_taken;
   logic [PC_W-1:0] res_pc;
   logic [2:0]      flags_q;

   fbu_state_t      dbg_state;
   logic [1:0]      dbg_cnt;

   modport slave (
      input  alu_issue, alu_done, alu_op, alu_flags,
      input  br_valid, br_cond, br_target, pc_plus1, flush,
      output issue_stall, br_ready, res_valid, res_taken, res_pc, flags_q,
      output dbg_state, dbg_cnt
   );

   modport master (
      output alu_issue, alu_done, alu_op, alu_flags,
      output br_valid, br_cond, br_target, pc_plus1, flush,
      input  issue_stall, br_ready, res_valid, res_taken, res_pc, flags_q,
      input  dbg_state, dbg_cnt
   );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator over the [Z,V,N] flags.
module branch_cond_eval
   import wisc_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] flags,
   output logic       taken
);

   logic z, v, n;

   assign z = flags[FLAG_Z];
   assign v = flags[FLAG_V];
   assign n = flags[FLAG_N];

   always_comb begin
      taken = 1'b0;
      case (br_cond_t'(cond))
         BR_NEQ:    taken = !z;
         BR_EQ:     taken = z;
         BR_GT:     taken = !z && !n;
         BR_LT:     taken = n;
         BR_GTE:    taken = z || !n;
         BR_LTE:    taken = n || z;
         BR_OVFL:   taken = v;
         BR_UNCOND: taken = 1'b1;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register, in-flight flag-op counter and branch resolver
// that waits until no flag-setting op is outstanding before picking the next PC.
module flag_branch_unit
   import wisc_pkg::*;
#(
   parameter int PC_W    = 16,
   parameter int MAX_OUT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   flag_branch_unit_if.slave     bus
);

   localparam logic [1:0] CNT_MAX = 2'(MAX_OUT);

   fbu_state_t      state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [2:0]      flag_q, flag_d;
   logic [2:0]      cond_q, cond_d;
   logic [PC_W-1:0] target_q, target_d;
   logic [PC_W-1:0] pc1_q, pc1_d;
   logic            res_taken_q, res_taken_d;
   logic [PC_W-1:0] res_pc_q, res_pc_d;

   logic            flag_wr, dec, enter_resolve, eval_taken;
   logic [2:0]      eval_cond;
   logic [PC_W-1:0] eval_target, eval_pc1;

   // A done with nothing outstanding is spurious, so it cannot cancel an issue.
   always_comb begin
      flag_wr = bus.alu_done && is_flag_op(bus.alu_op);
      flag_d  = flag_wr ? bus.alu_flags : flag_q;
      dec     = flag_wr && (cnt_q != 2'd0);
      cnt_d   = cnt_q;
      if (bus.alu_issue && dec)
         cnt_d = cnt_q;
      else if (bus.alu_issue && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + 2'd1;
      else if (dec)
         cnt_d = cnt_q - 2'd1;
   end

   always_comb begin
      state_d  = state_q;
      cond_d   = cond_q;
      target_d = target_q;
      pc1_d    = pc1_q;
      case (state_q)
         FBU_IDLE: begin
            if (bus.br_valid) begin
               cond_d   = bus.br_cond;
               target_d = bus.br_target;
               pc1_d    = bus.pc_plus1;
               state_d  = (cnt_d == 2'd0) ? FBU_RESOLVE : FBU_WAIT_FLAGS;
            end
         end
         FBU_WAIT_FLAGS: if (cnt_d == 2'd0) state_d = FBU_RESOLVE;
         FBU_RESOLVE:    state_d = FBU_IDLE;
         default:        state_d = FBU_IDLE;
      endcase
      if (bus.flush) state_d = FBU_IDLE;
   end

   // In IDLE the request has not been captured yet, so evaluate straight from the bus.
   assign eval_cond   = (state_q == FBU_IDLE) ? bus.br_cond   : cond_q;
   assign eval_target = (state_q == FBU_IDLE) ? bus.br_target : target_q;
   assign eval_pc1    = (state_q == FBU_IDLE) ? bus.pc_plus1  : pc1_q;

   branch_cond_eval u_eval (
      .cond  (eval_cond),
      .flags (flag_d),
      .taken (eval_taken)
   );

   always_comb begin
      enter_resolve = (state_d == FBU_RESOLVE) && (state_q != FBU_RESOLVE);
      res_taken_d   = res_taken_q;
      res_pc_d      = res_pc_q;
      if (enter_resolve) begin
         res_taken_d = eval_taken;
         res_pc_d    = eval_taken ? eval_target : eval_pc1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= FBU_IDLE;
         cnt_q       <= 2'd0;
         flag_q      <= 3'b000;
         cond_q      <= 3'b000;
         target_q    <= '0;
         pc1_q       <= '0;
         res_taken_q <= 1'b0;
         res_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flag_q      <= flag_d;
         cond_q      <= cond_d;
         target_q    <= target_d;
         pc1_q       <= pc1_d;
         res_taken_q <= res_taken_d;
         res_pc_q    <= res_pc_d;
      end
   end

   assign bus.issue_stall = (cnt_q == CNT_MAX);
   assign bus.br_ready    = (state_q == FBU_IDLE);
   assign bus.res_valid   = (state_q == FBU_RESOLVE) && !bus.flush;
   assign bus.res_taken   = res_taken_q;
   assign bus.res_pc      = res_pc_q;
   assign bus.flags_q     = flag_q;
   assign bus.dbg_state   = state_q;
   assign bus.dbg_cnt     = cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: condition table sweep plus hand sequences for
// hazards, same-cycle events, saturation, flush and mid-operation reset.
module tb_flag_branch_unit;
   import wisc_pkg::*;

   localparam int PC_W = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   flag_branch_unit_if #(.PC_W(PC_W)) bus ();

   flag_branch_unit #(.PC_W(PC_W), .MAX_OUT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_run  = 0;
   int n_fail = 0;
   logic [PC_W:0] exp_q[$];
   logic [PC_W:0] mon_e;

   typedef struct {
      logic [2:0]      flags;
      logic [2:0]      cond;
      logic [PC_W-1:0] target;
      logic [PC_W-1:0] pc1;
      logic            exp_taken;
   } vec_t;
   vec_t vec[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.alu_issue = 1'b0;
      bus.alu_done  = 1'b0;
      bus.br_valid  = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic set_flags(input logic [2:0] op, input logic [2:0] f);
      bus.alu_done  = 1'b1;
      bus.alu_op    = op;
      bus.alu_flags = f;
      tick();
   endtask

   task automatic drive_br(input logic [2:0] c, input logic [PC_W-1:0] t, input logic [PC_W-1:0] p);
      bus.br_valid  = 1'b1;
      bus.br_cond   = c;
      bus.br_target = t;
      bus.pc_plus1  = p;
   endtask

   // Scoreboard: every resolution strobe must match the oldest expected result.
   always @(negedge clk) begin
      if (bus.res_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected_res: got res_valid=1, want no resolution");
         end else begin
            mon_e = exp_q.pop_front();
            check("res_taken_pc", {15'd0, bus.res_taken, bus.res_pc}, {15'd0, mon_e});
         end
      end
   end

   // Outstanding-op model, used to flag an issue into a full unit.
   logic [1:0] m_cnt;
   logic       m_fd;
   assign m_fd = bus.alu_done && (bus.alu_op <= 3'd4);
   always @(posedge clk) begin
      if (!rst_n) begin
         m_cnt <= 2'd0;
      end else begin
         if (bus.alu_issue && m_cnt == 2'd3 && !m_fd) begin
            n_run++;
            n_fail++;
            $display("FAIL proto_issue_full: got issue at cnt=3, want none");
         end
         if (bus.alu_issue && m_fd && m_cnt != 2'd0) m_cnt <= m_cnt;
         else if (bus.alu_issue && m_cnt != 2'd3) m_cnt <= m_cnt + 2'd1;
         else if (m_fd && m_cnt != 2'd0)          m_cnt <= m_cnt - 2'd1;
      end
   end

   initial begin
      logic exp_t;
      vec[0]  = '{3'b100, BR_EQ,     16'h0040, 16'h0011, 1'b1};
      vec[1]  = '{3'b100, BR_NEQ,    16'h0, 16'h0, 1'b0};
      vec[2]  = '{3'b000, BR_NEQ,    16'h0, 16'h0, 1'b1};
      vec[3]  = '{3'b000, BR_GT,     16'h0, 16'h0, 1'b1};
      vec[4]  = '{3'b001, BR_GT,     16'h0, 16'h0, 1'b0};
      vec[5]  = '{3'b100, BR_GT,     16'h0, 16'h0, 1'b0};
      vec[6]  = '{3'b001, BR_LT,     16'h0, 16'h0, 1'b1};
      vec[7]  = '{3'b000, BR_LT,     16'h0, 16'h0, 1'b0};
      vec[8]  = '{3'b100, BR_GTE,    16'h0, 16'h0, 1'b1};
      vec[9]  = '{3'b001, BR_GTE,    16'h0, 16'h0, 1'b0};
      vec[10] = '{3'b101, BR_GTE,    16'h0, 16'h0, 1'b1};
      vec[11] = '{3'b000, BR_LTE,    16'h0, 16'h0, 1'b0};
      vec[12] = '{3'b001, BR_LTE,    16'h0, 16'h0, 1'b1};
      vec[13] = '{3'b010, BR_OVFL,   16'h0, 16'h0, 1'b1};
      vec[14] = '{3'b101, BR_OVFL,   16'h0, 16'h0, 1'b0};
      vec[15] = '{3'b000, BR_UNCOND, 16'h0, 16'h0, 1'b1};
      vec[16] = '{3'b101, BR_GT,     16'h0, 16'h0, 1'b0};
      for (int i = 1; i < 17; i++) begin
         vec[i].target = 16'($urandom_range(0, 65535));
         vec[i].pc1    = 16'($urandom_range(0, 65535));
         if (vec[i].pc1 == vec[i].target) vec[i].pc1 = ~vec[i].target;
      end

      bus.alu_issue = 1'b0; bus.alu_done = 1'b0; bus.alu_op = 3'd0; bus.alu_flags = 3'd0;
      bus.br_valid = 1'b0; bus.br_cond = 3'd0; bus.br_target = '0; bus.pc_plus1 = '0;
      bus.flush = 1'b0;

      // Reset values
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      check("rst_br_ready", bus.br_ready, 1);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_taken", bus.res_taken, 0);
      check("rst_res_pc", bus.res_pc, 0);
      check("rst_flags", bus.flags_q, 0);
      check("rst_stall", bus.issue_stall, 0);
      check("rst_cnt", bus.dbg_cnt, 0);

      // Flag latch: ADD writes, SRA does not
      set_flags(ALU_ADD, 3'b100);
      check("flag_add", bus.flags_q, 3'b100);
      set_flags(ALU_SRA, 3'b011);
      check("flag_sra_hold", bus.flags_q, 3'b100);
      set_flags(ALU_SLL, 3'b111);
      check("flag_sll_hold", bus.flags_q, 3'b100);

      // Condition table, no hazard: resolution in the cycle after accept
      for (int i = 0; i < 17; i++) begin
         set_flags(3'($urandom_range(0, 4)), vec[i].flags);
         check("vec_flags", bus.flags_q, vec[i].flags);
         check("vec_ready", bus.br_ready, 1);
         drive_br(vec[i].cond, vec[i].target, vec[i].pc1);
         exp_q.push_back({vec[i].exp_taken, vec[i].exp_taken ? vec[i].target : vec[i].pc1});
         tick();
         check("vec_latency", bus.res_valid, 1);
         check("vec_busy", bus.br_ready, 0);
         tick();
         check("vec_back_idle", bus.br_ready, 1);
         check("vec_hold_taken", bus.res_taken, vec[i].exp_taken);
      end

      // Hazard wait: two ops outstanding, GT must use the last op's flags
      bus.alu_issue = 1'b1; tick();
      bus.alu_issue = 1'b1; tick();
      check("hz_cnt2", bus.dbg_cnt, 2);
      drive_br(BR_GT, 16'h1234, 16'h0101);
      exp_q.push_back({1'b0, 16'h0101});
      tick();
      check("hz_wait", bus.dbg_state, FBU_WAIT_FLAGS);
      check("hz_not_ready", bus.br_ready, 0);
      set_flags(ALU_ADD, 3'b000);
      check("hz_still_wait", bus.dbg_state, FBU_WAIT_FLAGS);
      check("hz_no_res", bus.res_valid, 0);
      set_flags(ALU_SUB, 3'b001);
      check("hz_res_valid", bus.res_valid, 1);
      check("hz_flags", bus.flags_q, 3'b001);
      tick();

      // Accept together with the last done: OVFL sees the fresh V
      bus.alu_issue = 1'b1; tick();
      drive_br(BR_OVFL, 16'h0abc, 16'h0077);
      bus.alu_done = 1'b1; bus.alu_op = ALU_ADD; bus.alu_flags = 3'b010;
      exp_q.push_back({1'b1, 16'h0abc});
      tick();
      check("sc_res_valid", bus.res_valid, 1);
      check("sc_res_taken", bus.res_taken, 1);
      check("sc_cnt", bus.dbg_cnt, 0);
      tick();

      // Accept together with an issue must wait
      drive_br(BR_UNCOND, 16'h2222, 16'h3333);
      bus.alu_issue = 1'b1;
      exp_q.push_back({1'b1, 16'h2222});
      tick();
      check("ai_wait", bus.dbg_state, FBU_WAIT_FLAGS);
      check("ai_cnt", bus.dbg_cnt, 1);
      set_flags(ALU_XOR, 3'b000);
      check("ai_res_valid", bus.res_valid, 1);
      tick();

      // Saturation
      repeat (3) begin bus.alu_issue = 1'b1; tick(); end
      check("sat_stall", bus.issue_stall, 1);
      check("sat_cnt3", bus.dbg_cnt, 3);
      bus.alu_issue = 1'b1; bus.alu_done = 1'b1; bus.alu_op = ALU_ADD; bus.alu_flags = 3'b000;
      tick();
      check("sat_both_cnt", bus.dbg_cnt, 3);
      check("sat_both_stall", bus.issue_stall, 1);
      set_flags(ALU_ADD, 3'b000);
      check("sat_release", bus.issue_stall, 0);
      check("sat_cnt2", bus.dbg_cnt, 2);
      set_flags(ALU_ADD, 3'b000);
      set_flags(ALU_ADD, 3'b000);
      check("sat_drained", bus.dbg_cnt, 0);
      set_flags(ALU_SUB, 3'b000);
      check("sat_floor", bus.dbg_cnt, 0);

      // Flush in WAIT_FLAGS abandons the branch but keeps the counter
      bus.alu_issue = 1'b1; tick();
      drive_br(BR_EQ, 16'h0f0f, 16'h0f10);
      tick();
      check("fl_wait", bus.dbg_state, FBU_WAIT_FLAGS);
      bus.flush = 1'b1;
      tick();
      check("fl_idle", bus.dbg_state, FBU_IDLE);
      check("fl_no_res", bus.res_valid, 0);
      check("fl_cnt", bus.dbg_cnt, 1);
      check("fl_ready", bus.br_ready, 1);
      set_flags(ALU_ADD, 3'b100);
      check("fl_stay_idle", bus.dbg_state, FBU_IDLE);
      check("fl_flags", bus.flags_q, 3'b100);

      // Flush on the accept cycle discards the request
      drive_br(BR_UNCOND, 16'h4444, 16'h4445);
      bus.flush = 1'b1;
      tick();
      check("fla_idle", bus.dbg_state, FBU_IDLE);
      check("fla_no_res", bus.res_valid, 0);
      tick();
      check("fla_no_res2", bus.res_valid, 0);

      // Reset asserted in RESOLVE
      bus.alu_issue = 1'b1; tick();
      drive_br(BR_LTE, 16'h5a5a, 16'h0102);
      bus.alu_done = 1'b1; bus.alu_op = ALU_PADDSB; bus.alu_flags = 3'b101;
      exp_t = 1'b1;
      exp_q.push_back({exp_t, 16'h5a5a});
      tick();
      check("mr_res_valid", bus.res_valid, 1);
      rst_n = 1'b0;
      bus.alu_issue = 1'b1;
      tick();
      check("mr_res_valid0", bus.res_valid, 0);
      check("mr_res_taken", bus.res_taken, 0);
      check("mr_res_pc", bus.res_pc, 0);
      check("mr_flags", bus.flags_q, 0);
      check("mr_cnt", bus.dbg_cnt, 0);
      check("mr_stall", bus.issue_stall, 0);
      check("mr_ready", bus.br_ready, 1);
      rst_n = 1'b1;
      tick();
      check("mr_after", bus.res_valid, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Consumer of the ALU's `[Z,V,N]` flag output. It holds the architectural flag register and tracks flag-setting ALU operations that are still in flight. It accepts conditional branch requests from decode and resolves each one to taken or not-taken, with a next-PC value, once the flags it depends on are final. It sits between the ALU writeback point and the PC-select logic of the fetch stage.

## Interface
Parameters:
- `PC_W`, default 16: PC and branch target width.
- `MAX_OUT`, default 3: maximum number of flag-setting ALU ops in flight. The counter is 2 bits wide.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `alu_issue`  in  1: a flag-setting ALU op (opcode 0–4) is issued this cycle.
- `alu_done`  in  1: one-cycle writeback pulse for the ALU result.
- `alu_op`  in  3: opcode accompanying `alu_done`.
- `alu_flags`  in  3: ALU flags `[Z,V,N]`, valid with `alu_done`.
- `issue_stall`  out  1: high when the outstanding count equals `MAX_OUT`.
- `br_valid`  in  1: branch request valid.
- `br_ready`  out  1: unit can accept a branch request.
- `br_cond`  in  3: branch condition code.
- `br_target`  in  PC_W: taken-path PC.
- `pc_plus1`  in  PC_W: fall-through PC.
- `flush`  in  1: pipeline flush; abandons any pending branch.
- `res_valid`  out  1: one-cycle resolution strobe.
- `res_taken`  out  1: branch is taken.
- `res_pc`  out  PC_W: selected next PC.
- `flags_q`  out  3: architectural flag register `[Z,V,N]`.

## Operation
- **Flag register.** On `alu_done` with `alu_op` in 0–4, `flags_q <= alu_flags`. Opcodes 5–7 (the shifts) leave `flags_q` unchanged.
- **Outstanding counter (`cnt`).**
  - `+1` on `alu_issue`, `-1` on `alu_done` with a flag-setting op.
  - Both in the same cycle leaves it unchanged.
  - A done pulse with `cnt==0` does not decrement; the counter saturates at 0.
  - An issue while `cnt==MAX_OUT` is a protocol error. The counter holds, and the bench asserts that this never happens.
  - `cnt_next` denotes the value `cnt` will take at the next edge.
- **Branch conditions** (`br_cond`):
  - 000 NEQ: `!Z`
  - 001 EQ: `Z`
  - 010 GT: `!Z && !N`
  - 011 LT: `N`
  - 100 GTE: `Z || !N`
  - 101 LTE: `N || Z`
  - 110 OVFL: `V`
  - 111 UNCOND: 1
- **FSM states:** IDLE, WAIT_FLAGS, RESOLVE.
  - **IDLE.** `br_ready=1`. On `br_valid`, capture `br_cond`, `br_target` and `pc_plus1`. Then go to RESOLVE if `cnt_next==0`, else WAIT_FLAGS.
  - **WAIT_FLAGS.** `br_ready=0`. Go to RESOLVE when `cnt_next==0`.
  - **RESOLVE.** `res_valid=1` for exactly one cycle, then return to IDLE.
- **Result registers.** `res_taken` and `res_pc` are registered on every entry to RESOLVE and are evaluated from the flag value being written at that edge. If `alu_done` arrives at the same edge, the fresh `alu_flags` are used; otherwise the current `flags_q`.
  - `res_pc = taken ? br_target : pc_plus1`
  - Both hold their values outside RESOLVE.
- **Flush.** `flush` in any state forces IDLE at the next edge and suppresses `res_valid` that cycle.
  - `cnt` and `flags_q` are not affected.
  - A flush during the accept cycle discards the request.

## Timing
- **Reset values:**
  - `flags_q=000`, `cnt=0`, state IDLE.
  - `res_valid=0`, `res_taken=0`, `res_pc=0`.
  - `br_ready=1` in the first cycle after reset.
  - `issue_stall=0`.
- **Latency:**
  - Accept in cycle N with `cnt_next==0` gives `res_valid` in cycle N+1.
  - Otherwise `res_valid` comes one cycle after the edge at which `cnt` reaches 0.
- **Throughput:** at most one branch every 2 cycles, because `br_ready` is low during RESOLVE.
- **Same-cycle events:**
  - Accept together with the last `alu_done` resolves at N+1 using that op's flags.
  - Accept together with `alu_issue` goes to WAIT_FLAGS.
- `issue_stall` is combinational from `cnt`.
- Reset asserted mid-operation returns every register to its reset value at the next edge. No `res_valid` is produced.

## Structure
- **Shared package `wisc_pkg`:**
  - ALU opcode localparams (ADD..SLL = 0..7).
  - `br_cond_t` enum for the 8 condition codes.
  - Flag bit index constants `FLAG_Z=2`, `FLAG_V=1`, `FLAG_N=0`.
  - `fbu_state_t` enum for the FSM states.
- **Sub-module `branch_cond_eval`:** purely combinational; inputs `cond` and `flags`, output `taken`. It is reused by the ISA reference model.

## Test plan
- **Reset and flag latch.** Reset, then `alu_done` with op=ADD and flags=100 → `flags_q=100`. Then op=SRA with flags=011 → `flags_q` stays 100.
- **No-hazard branch.** `cnt=0`, `flags_q=100`, EQ branch with target=0x0040 and pc_plus1=0x0011 → cycle N+1: `res_valid=1`, `res_taken=1`, `res_pc=0x0040`.
- **Hazard wait.** Issue 2 ops, then GT branch → WAIT_FLAGS, `br_ready=0`. First done with flags=000, second done with flags=001 → resolves one cycle later with `res_taken=0` and `res_pc=pc_plus1`.
- **Same-cycle accept and last done.** `cnt=1`; branch accepted in the same cycle as `alu_done` with flags=010, cond=OVFL → N+1 gives `res_taken=1`.
- **Saturation.** 3 issues → `issue_stall=1`. Issue and done in the same cycle → `cnt` stays 3. One done → `issue_stall=0`.
- **Flush and mid-operation reset.** Flush in WAIT_FLAGS → IDLE, no `res_valid`, `cnt` preserved. Reset asserted in RESOLVE → `res_valid=0` next cycle and all outputs at reset values.
